// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and small helpers for the load/store sequencer.
// Imported by the interface, the lane aligner and the top.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [15:0] MMIO_PREFIX_DEFAULT = 16'hffff;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Unused funct3 encodings (x11) are treated as word accesses.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        case (f3_size(f3))
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] zext_store(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] res;
        case (f3_size(f3))
            SZ_BYTE: res = {24'd0, data[7:0]};
            SZ_HALF: res = {16'd0, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-memory port B signals of the load/store sequencer.
// Request handshake: a request is taken on a clock edge where req_valid and req_ready are both high.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    state_e      dbg_state;

    modport slave (
        input  req_valid, req_funct3, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_done, resp_rdata, resp_misaligned,
               mem_addr, mem_wdata, mem_we, dbg_state
    );

    modport master (
        output req_valid, req_funct3, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_done, resp_rdata, resp_misaligned,
               mem_addr, mem_wdata, mem_we, dbg_state
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data, and merges
// sub-word store data into a previously read word.
module byte_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_new_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [31:0] w_shifted;
    logic        w_unsigned;
    size_e       w_size;

    assign w_shifted  = i_word >> {i_offset, 3'b000};
    assign w_unsigned = i_funct3[2];
    assign w_size     = f3_size(i_funct3);

    always_comb begin
        o_load_data = i_word;
        case (w_size)
            SZ_BYTE: o_load_data = w_unsigned ? {24'd0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_load_data = w_unsigned ? {16'd0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_load_data = i_word;
        endcase
    end

    // Only the addressed lane changes; the rest of the old word is written back as read.
    always_comb begin
        o_store_word = i_word;
        case (w_size)
            SZ_BYTE: o_store_word[{i_offset, 3'b000} +: 8]     = i_new_data[7:0];
            SZ_HALF: o_store_word[{i_offset[1], 4'b0000} +: 16] = i_new_data[15:0];
            default: o_store_word = i_new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of data-memory port B: aligned word accesses,
// read-modify-write for sub-word RAM stores, direct sub-word MMIO stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] MMIO_PREFIX  = MMIO_PREFIX_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    state_e      r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_offset;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_resp_done;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misaligned;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_is_mmio;
    logic        w_direct_write;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_accept       = bus.req_valid && (r_state == ST_IDLE);
    assign w_misaligned   = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_is_mmio      = (bus.req_addr[31:16] == MMIO_PREFIX);
    // Word stores and MMIO stores skip the read; only sub-word RAM stores need RMW.
    assign w_direct_write = (f3_size(bus.req_funct3) == SZ_WORD) || w_is_mmio;

    byte_lane_align u_align (
        .i_word       (bus.mem_rdata),
        .i_offset     (r_offset),
        .i_funct3     (r_funct3),
        .i_new_data   (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_cnt             <= 2'd0;
            r_offset          <= 2'd0;
            r_funct3          <= 3'd0;
            r_wdata           <= 32'd0;
            r_write           <= 1'b0;
            r_mem_addr        <= 32'd0;
            r_mem_wdata       <= 32'd0;
            r_mem_we          <= 1'b0;
            r_resp_done       <= 1'b0;
            r_resp_rdata      <= 32'd0;
            r_resp_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_offset   <= bus.req_addr[1:0];
                        r_funct3   <= bus.req_funct3;
                        r_wdata    <= bus.req_wdata;
                        r_write    <= bus.req_write;
                        r_mem_addr <= {bus.req_addr[31:2], 2'b00};
                        if (w_misaligned) begin
                            r_state           <= ST_FAULT;
                            r_resp_done       <= 1'b1;
                            r_resp_misaligned <= 1'b1;
                            r_resp_rdata      <= 32'd0;
                        end else if (bus.req_write && w_direct_write) begin
                            r_state     <= ST_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= zext_store(bus.req_funct3, bus.req_wdata);
                            if (w_is_mmio) begin
                                r_mem_addr <= bus.req_addr;
                            end
                        end else begin
                            r_state <= ST_READ;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end

                ST_READ: begin
                    if (r_cnt == 2'd0) begin
                        if (r_write) begin
                            r_state     <= ST_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_store_word;
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_rdata <= w_load_data;
                            r_resp_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end

                ST_WRITE: begin
                    r_state           <= ST_RESP;
                    r_mem_we          <= 1'b0;
                    r_resp_done       <= 1'b1;
                    r_resp_misaligned <= 1'b0;
                end

                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_resp_done <= 1'b0;
                end

                ST_FAULT: begin
                    r_state           <= ST_IDLE;
                    r_resp_done       <= 1'b0;
                    r_resp_misaligned <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_we    <= 1'b0;
                    r_resp_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready       = (r_state == ST_IDLE);
    assign bus.resp_done       = r_resp_done;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_misaligned = r_resp_misaligned;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_we          = r_mem_we;
    assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a word-addressed RAM model on port B,
// expected responses and writes queued at issue time and checked by monitors.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int W = 66;  // {check_rdata, misaligned, mem_addr, rdata}

  logic clk;
  logic reset;
  mem_access_unit_if bus ();

  mem_access_unit #(.READ_LATENCY(1), .MMIO_PREFIX(16'hffff)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM model: combinational read, writes ignored for the MMIO window
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_addr[31:16] != 16'hffff) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [63:0]  wr_q[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int acc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [63:0]  w;
    int           l;
    ncyc++;
    if (bus.req_valid && bus.req_ready && !reset) acc_n = ncyc;
    if (bus.resp_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("resp_latency", ncyc - acc_n, l);
        check("resp_misaligned", {31'd0, bus.resp_misaligned}, {31'd0, e[64]});
        check("resp_mem_addr", bus.mem_addr, e[63:32]);
        if (e[65]) check("resp_rdata", bus.resp_rdata, e[31:0]);
      end
    end
    if (bus.mem_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_mem_we", {31'd0, bus.mem_we}, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", bus.mem_addr, w[63:32]);
        check("write_data", bus.mem_wdata, w[31:0]);
      end
    end
  end

  // driver tasks
  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_resp, input logic chk_rd,
                      input logic [31:0] exp_rdata, input logic exp_mis,
                      input logic [31:0] exp_maddr, input int exp_lat,
                      input logic exp_wr, input logic [31:0] exp_wdata);
    if (exp_resp) begin
      exp_q.push_back({chk_rd, exp_mis, exp_maddr, exp_rdata});
      lat_q.push_back(exp_lat);
    end
    if (exp_wr) wr_q.push_back({exp_maddr, exp_wdata});
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!bus.req_ready && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    send(1'b0, f3, addr, 32'h0, 1'b1, 1'b1, rdata, 1'b0, {addr[31:2], 2'b00}, 2, 1'b0, 32'h0);
    wait_idle();
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] maddr, input logic [31:0] mwdata, input int lat);
    send(1'b1, f3, addr, wdata, 1'b1, 1'b0, 32'h0, 1'b0, maddr, lat, 1'b1, mwdata);
    wait_idle();
  endtask

  task automatic fault(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    send(wr, f3, addr, 32'h5a5a5a5a, 1'b1, 1'b1, 32'h0, 1'b1, {addr[31:2], 2'b00}, 1, 1'b0, 32'h0);
    wait_idle();
  endtask

  // stimulus
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;  // 0x10
    mem[8]  = 32'h01020304;  // 0x20
    mem[11] = 32'h11112222;  // 0x2C
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_resp_done", {31'd0, bus.resp_done}, 32'd0);
    check("rst_misaligned", {31'd0, bus.resp_misaligned}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);

    // loads and extension
    load(F3_LW,  32'h10, 32'hDEADBEEF);
    load(F3_LB,  32'h13, 32'hFFFFFFDE);
    load(F3_LBU, 32'h13, 32'h000000DE);
    load(F3_LH,  32'h12, 32'hFFFFDEAD);
    load(F3_LHU, 32'h10, 32'h0000BEEF);

    // read-modify-write byte store, then read back
    store(F3_SB, 32'h11, 32'h12345655, 32'h10, 32'hDEAD55EF, 3);
    load(F3_LW, 32'h10, 32'hDEAD55EF);

    // misaligned accesses
    fault(1'b0, F3_LH,  32'h01);
    fault(1'b1, F3_SW,  32'h12);
    fault(1'b0, F3_LW,  32'h13);
    fault(1'b0, F3_LHU, 32'h03);
    fault(1'b1, F3_SH,  32'h25);

    // MMIO sub-word stores: full address, zero-extended data, no read
    store(F3_SB, 32'hFFFFFC60, 32'h000000AB, 32'hFFFFFC60, 32'h000000AB, 2);
    store(F3_SH, 32'hFFFF0006, 32'h9999BEEF, 32'hFFFF0006, 32'h0000BEEF, 2);

    // half store RMW in upper lane
    store(F3_SH, 32'h22, 32'hAAAA1234, 32'h20, 32'h12340304, 3);
    load(F3_LHU, 32'h22, 32'h00001234);
    load(F3_LB,  32'h20, 32'h00000004);
    load(F3_LH,  32'h20, 32'h00000304);

    // word store and byte store into top lane
    store(F3_SW, 32'h24, 32'hCAFEF00D, 32'h24, 32'hCAFEF00D, 2);
    load(F3_LW, 32'h24, 32'hCAFEF00D);
    load(F3_LB, 32'h25, 32'hFFFFFFF0);
    store(F3_SB, 32'h27, 32'h00000080, 32'h24, 32'h80FEF00D, 3);
    load(F3_LB, 32'h27, 32'hFFFFFF80);

    // request while busy must be ignored
    send(1'b1, F3_SW, 32'h28, 32'h13579BDF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h28, 2, 1'b1, 32'h13579BDF);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 32'h2C;
    bus.req_wdata  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_idle();
    load(F3_LW, 32'h2C, 32'h11112222);
    load(F3_LW, 32'h28, 32'h13579BDF);

    // reset during the read phase of a RAM byte store
    send(1'b1, F3_SB, 32'h11, 32'h00000077, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 0, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("post_reset_done", {31'd0, bus.resp_done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    load(F3_LW, 32'h10, 32'hDEAD55EF);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
